unified_mem_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data memory between two requesters: the pipeline fetch stage (I-port, read only) and the memory stage (D-port, read/write).
- Sequences each transaction through the memory handshake with one transaction outstanding at a time.
- Returns an ack to the owning requester; the hazard logic uses that ack to release StallF/StallD.
- Data accesses take priority. A starvation counter guarantees fetch progress.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_priority_sel.sv | 43 ++++
 rtl/unified_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and width defaults for the unified memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_t;

    localparam int AW_DEF         = 32;
    localparam int DW_DEF         = 32;
    localparam int STARVE_MAX_DEF = 4;
    localparam int STARVE_W       = 4;

endpackage

// File: rtl/arb_priority_sel.sv
// rtl/arb_priority_sel.sv - data-first grant decision with a fetch starvation counter
module arb_priority_sel
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_arb_en,
    input  logic i_fetch_req,
    input  logic i_data_req,
    output logic o_grant_i,
    output logic o_grant_d
);

    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] r_starve_cnt;
    logic                w_force_i;

    // Once fetch has lost STARVE_MAX arbitrations in a row it wins the next one.
    always_comb begin
        w_force_i = (r_starve_cnt == STARVE_LIMIT);
        o_grant_d = i_arb_en && i_data_req && !(i_fetch_req && w_force_i);
        o_grant_i = i_arb_en && i_fetch_req && (!i_data_req || w_force_i);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (i_arb_en) begin
            if (o_grant_i || !i_fetch_req) begin
                r_starve_cnt <= '0;
            end else if (o_grant_d && (r_starve_cnt != STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
            end
        end
    end

    a_starve_bound: assert property (@(posedge clk) disable iff (!reset)
        r_starve_cnt <= STARVE_LIMIT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-ported memory between fetch and data requesters
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_t    r_state;
    arb_state_t    w_next_state;
    arb_owner_t    r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_i_ack;
    logic          r_d_ack;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;

    logic w_arb_en;
    logic w_grant_i;
    logic w_grant_d;
    logic w_accept;
    logic w_read_done;

    arb_priority_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .clk         (clk),
        .reset       (reset),
        .i_arb_en    (w_arb_en),
        .i_fetch_req (i_req),
        .i_data_req  (d_req),
        .o_grant_i   (w_grant_i),
        .o_grant_d   (w_grant_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_arb_en     = 1'b0;
        w_accept     = 1'b0;
        w_read_done  = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (r_state)
            IDLE: begin
                w_arb_en = 1'b1;
                if (w_grant_i || w_grant_d) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                if (mem_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = r_we ? IDLE : RESP;
                end
            end
            RESP: begin
                // Only reachable after acceptance, so a same-cycle rvalid is never seen here.
                if (mem_rvalid) begin
                    w_read_done  = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Owner fields are captured at grant so requester changes mid-transaction are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_owner   <= OWN_NONE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            if (w_grant_d) begin
                r_owner <= OWN_D;
                r_we    <= d_we;
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
            end else if (w_grant_i) begin
                r_owner <= OWN_I;
                r_we    <= 1'b0;
                r_addr  <= i_addr;
                r_wdata <= '0;
            end
            if (w_accept && r_we) begin
                r_d_ack <= 1'b1;
                r_owner <= OWN_NONE;
            end
            if (w_read_done) begin
                r_owner <= OWN_NONE;
                if (r_owner == OWN_D) begin
                    r_d_ack   <= 1'b1;
                    r_d_rdata <= mem_rdata;
                end else if (r_owner == OWN_I) begin
                    r_i_ack   <= 1'b1;
                    r_i_rdata <= mem_rdata;
                end
            end
        end
    end

    assign i_ack   = r_i_ack;
    assign d_ack   = r_d_ack;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign busy    = (r_state != IDLE);

    a_ack_exclusive: assert property (@(posedge clk) disable iff (!reset)
        !(i_ack && d_ack));

    a_mem_req_in_req: assert property (@(posedge clk) disable iff (!reset)
        mem_req |-> (r_state == REQ));

    a_no_rvalid_at_accept: assert property (@(posedge clk) disable iff (!reset)
        (mem_req && mem_ready) |-> !mem_rvalid);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, i_ack, d_req, d_we, d_ack;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
    logic          mem_req, mem_we, mem_ready, mem_rvalid, busy;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    typedef struct {
        bit          fetch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rwait;
        int          rvdly;
        logic [31:0] rdata;
        int          exp_cycles;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] ref_arr [logic [31:0]];
    bit          pend;
    int          pend_dly;
    logic [31:0] pend_addr;
    int          rw_left, max_wait, max_rv;
    logic [31:0] exp_i_rdata, exp_d_rdata;
    vec_t        vecs [8];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_arr.exists(a)) return ref_arr[a];
        return dflt(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        pend = 0; rw_left = 0;
        exp_i_rdata = 0; exp_d_rdata = 0;
    endtask

    // Memory responder for one cycle: accept after a random wait, return reads later.
    task automatic mem_step();
        mem_rvalid = 0;
        mem_rdata  = $urandom;
        if (pend) begin
            if (pend_dly == 0) begin
                mem_rvalid = 1; mem_rdata = mem_rd(pend_addr); pend = 0;
            end else pend_dly--;
        end
        mem_ready = 0;
        if (mem_req) begin
            if (rw_left == 0) begin
                mem_ready = 1;
                if (mem_we) mem_arr[mem_addr] = mem_wdata;
                else begin
                    pend = 1; pend_dly = $urandom_range(0, max_rv); pend_addr = mem_addr;
                end
                rw_left = $urandom_range(0, max_wait);
            end else rw_left--;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat, acks_ok, acks_bad, req_cycles, wait_left, rv_left;
        bit accepted, rv_sent, ready_now;
        lat = 0; acks_ok = 0; acks_bad = 0; req_cycles = 0;
        wait_left = v.rwait; rv_left = v.rvdly; accepted = 0; rv_sent = 0;
        if (v.fetch) begin
            i_req = 1; i_addr = v.addr;
        end else begin
            d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end
        for (int cyc = 1; cyc <= v.exp_cycles + 4; cyc++) begin
            ready_now = 0; mem_rvalid = 0; mem_rdata = 32'hDEADBEEF;
            if (mem_req) begin
                req_cycles++;
                check($sformatf("vec%0d_mem_addr", idx), mem_addr, v.addr);
                check($sformatf("vec%0d_mem_we", idx), mem_we, (!v.fetch && v.we));
                if (!v.fetch) check($sformatf("vec%0d_mem_wdata", idx), mem_wdata, v.wdata);
                if (wait_left == 0) ready_now = 1; else wait_left--;
            end
            if (accepted && !rv_sent && (v.fetch || !v.we)) begin
                if (rv_left == 0) begin
                    mem_rvalid = 1; mem_rdata = v.rdata; rv_sent = 1;
                end else rv_left--;
            end
            mem_ready = ready_now;
            @(negedge clk);
            if (ready_now) accepted = 1;
            if (v.fetch ? i_ack : d_ack) begin
                acks_ok++; lat = cyc + 1; i_req = 0; d_req = 0;
            end
            if (v.fetch ? d_ack : i_ack) acks_bad++;
        end
        mem_ready = 0; mem_rvalid = 0;
        if (v.fetch) exp_i_rdata = v.rdata;
        else if (!v.we) exp_d_rdata = v.rdata;
        check($sformatf("vec%0d_ack_count", idx), acks_ok, 1);
        check($sformatf("vec%0d_wrong_port_ack", idx), acks_bad, 0);
        check($sformatf("vec%0d_latency", idx), lat, v.exp_cycles);
        check($sformatf("vec%0d_req_cycles", idx), req_cycles, v.rwait + 1);
        check($sformatf("vec%0d_i_rdata", idx), i_rdata, exp_i_rdata);
        check($sformatf("vec%0d_d_rdata", idx), d_rdata, exp_d_rdata);
        check($sformatf("vec%0d_busy_after", idx), busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq_q[$];
        int ack1, ack2, req2;
        bit ip, dp, dwe;
        logic [31:0] ia, da, dwd;
        int iage, dage, d_while_i, n_i, n_d;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         0, 0, 32'hE3A0_0005, 4};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0064, 32'h7,         3, 0, 32'h0,         6};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         0, 0, 32'h0000_00AA, 4};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0014, 32'h1111_2222, 1, 2, 32'h0000_00BB, 7};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,         2, 1, 32'h1234_5678, 7};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0103, 32'hA5A5_5A5A, 0, 0, 32'h0,         3};
        vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0,         0, 3, 32'hCAFE_F00D, 7};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         0, 4, 32'h0,         8};

        // Reset held with both requests pending, then release.
        idle_inputs();
        reset = 0; pend = 0; rw_left = 0; max_wait = 0; max_rv = 0;
        exp_i_rdata = 0; exp_d_rdata = 0;
        i_req = 1; i_addr = 32'h80; d_req = 1; d_addr = 32'h40;
        repeat (2) @(negedge clk);
        check("reset_mem_req", mem_req, 0);
        check("reset_i_ack", i_ack, 0);
        check("reset_d_ack", d_ack, 0);
        check("reset_busy", busy, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_i_rdata", i_rdata, 0);
        check("reset_d_rdata", d_rdata, 0);
        reset = 1;
        @(negedge clk);
        check("release_mem_req", mem_req, 1);
        check("release_owner_d_addr", mem_addr, 32'h40);
        check("release_busy", busy, 1);
        do_reset();
        check("reset_in_req_busy", busy, 0);

        for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

        // Reset while waiting for read data; a late rvalid must be ignored.
        i_req = 1; i_addr = 32'h20;
        @(negedge clk);
        check("rst_mid_req", mem_req, 1);
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        check("rst_mid_in_resp", busy, 1);
        check("rst_mid_resp_no_req", mem_req, 0);
        reset = 0;
        @(negedge clk);
        reset = 1; i_req = 0; mem_rvalid = 1; mem_rdata = 32'h55;
        @(negedge clk);
        mem_rvalid = 0;
        check("rst_mid_i_ack", i_ack, 0);
        check("rst_mid_d_ack", d_ack, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_i_rdata", i_rdata, 0);
        check("rst_mid_d_rdata", d_rdata, 0);
        @(negedge clk);
        check("rst_mid_i_ack_later", i_ack, 0);
        exp_i_rdata = 0; exp_d_rdata = 0;

        // Back-to-back loads from the data port.
        mem_arr[32'h10] = 32'hAA; mem_arr[32'h14] = 32'hBB;
        pend = 0; rw_left = 0; max_wait = 0; max_rv = 0;
        ack1 = -1; ack2 = -1; req2 = -1;
        d_req = 1; d_we = 0; d_addr = 32'h10;
        for (int c = 1; c <= 30 && ack2 < 0; c++) begin
            mem_step();
            @(negedge clk);
            if (mem_req && mem_addr == 32'h14 && req2 < 0) req2 = c;
            if (d_ack) begin
                if (ack1 < 0) begin
                    ack1 = c;
                    check("b2b_first_rdata", d_rdata, 32'hAA);
                    check("b2b_idle_on_ack", busy, 0);
                    d_addr = 32'h14;
                end else begin
                    ack2 = c;
                    check("b2b_second_rdata", d_rdata, 32'hBB);
                    d_req = 0;
                end
            end
        end
        check("b2b_first_ack_cycle", ack1, 3);
        check("b2b_second_req_gap", req2 - ack1, 1);
        check("b2b_ack_spacing", ack2 - ack1, 3);

        // Continuous contention: fetch must win every (STARVE_MAX+1)th grant.
        do_reset();
        mem_arr.delete();
        i_req = 1; i_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200;
        for (int c = 0; c < 80 && seq_q.size() < 10; c++) begin
            mem_step();
            @(negedge clk);
            if (i_ack) begin
                seq_q.push_back(1);
                check("contention_i_rdata", i_rdata, dflt(32'h100));
            end
            if (d_ack) begin
                seq_q.push_back(0);
                check("contention_d_rdata", d_rdata, dflt(32'h200));
            end
        end
        for (int k = 0; k < 10; k++)
            check($sformatf("contention_grant%0d", k), (k < seq_q.size()) ? seq_q[k] : 2,
                  ((k % (STARVE_MAX + 1)) == STARVE_MAX) ? 1 : 0);
        do_reset();

        // Randomized traffic against a scoreboard of requester-visible memory.
        mem_arr.delete(); ref_arr.delete();
        max_wait = 2; max_rv = 2;
        ip = 0; dp = 0; dwe = 0; ia = 0; da = 0; dwd = 0;
        iage = 0; dage = 0; d_while_i = 0; n_i = 0; n_d = 0;
        for (int c = 0; c < 2000; c++) begin
            if (i_ack || d_ack) check("rand_ack_exclusive", i_ack & d_ack, 0);
            if (i_ack) begin
                check("rand_i_ack_owned", ip, 1);
                check("rand_i_rdata", i_rdata, ref_rd(ia));
                check("rand_i_starve_bound", (d_while_i <= STARVE_MAX + 1), 1);
                ip = 0; i_req = 0; n_i++;
            end
            if (d_ack) begin
                check("rand_d_ack_owned", dp, 1);
                if (dwe) ref_arr[da] = dwd;
                else check("rand_d_rdata", d_rdata, ref_rd(da));
                if (ip) d_while_i++;
                dp = 0; d_req = 0; n_d++;
            end
            if (ip) begin
                iage++;
                if (iage > 60) begin check("rand_i_timeout", iage, 0); ip = 0; i_req = 0; end
            end
            if (dp) begin
                dage++;
                if (dage > 60) begin check("rand_d_timeout", dage, 0); dp = 0; d_req = 0; end
            end
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1; iage = 0; d_while_i = 0;
                ia = 32'($urandom_range(0, 15)) << 2;
                i_req = 1; i_addr = ia;
            end
            if (!dp && $urandom_range(0, 1) == 0) begin
                dp = 1; dage = 0;
                da = 32'($urandom_range(0, 15)) << 2;
                dwe = 1'($urandom_range(0, 1));
                dwd = $urandom;
                d_req = 1; d_we = dwe; d_addr = da; d_wdata = dwd;
            end
            mem_step();
            @(negedge clk);
        end
        i_req = 0; d_req = 0;
        for (int c = 0; c < 50 && busy; c++) begin
            mem_step();
            @(negedge clk);
        end
        check("rand_drain_idle", busy, 0);
        check("rand_progress", (n_i > 50) && (n_d > 50), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
